// File: rtl/complex_mag_stream_pkg.sv
// Shared definitions for the complex-magnitude streaming multiply path.
//  - MUL_A_W / MUL_B_W / MUL_P_W : operand and product widths of the shared multiplier
//  - clog2()                      : index width helper, never returns less than 1
package complex_mag_stream_pkg;

  localparam int MUL_A_W = 41;
  localparam int MUL_B_W = 6;
  localparam int MUL_P_W = MUL_A_W + MUL_B_W;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/complex_mag_stream_mul_arbiter_if.sv
// Requester/result bundle of the shared-multiplier arbiter.
//  req_valid / req_ready : per-requester operand handshake (ready is one-hot or zero)
//  req_a / req_b         : packed operands, slice i belongs to requester i
//  res_valid / res_ready : shared result handshake
//  res_id / res_p        : issuing requester index and unsigned product
// Modports: master = requesters + result consumer, slave = arbiter.
interface complex_mag_stream_mul_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = complex_mag_stream_pkg::MUL_A_W,
  parameter int B_WIDTH  = complex_mag_stream_pkg::MUL_B_W,
  parameter int P_WIDTH  = complex_mag_stream_pkg::MUL_P_W,
  parameter int ID_WIDTH = complex_mag_stream_pkg::clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       res_valid;
  logic                       res_ready;
  logic [ID_WIDTH-1:0]        res_id;
  logic [P_WIDTH-1:0]         res_p;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_p
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_p
  );

endinterface

// File: rtl/complex_mag_stream_mul_41ns_6ns_47_2_1.sv
// Unsigned multiplier with one clock-enabled output register.
//  clk   : clock
//  reset : present for drop-in compatibility, has no effect
//  ce    : register enable; holding it low freezes dout
//  din0  : unsigned operand a
//  din1  : unsigned operand b
//  dout  : registered full-width product
module complex_mag_stream_mul_41ns_6ns_47_2_1 #(
  parameter int DIN0_WIDTH = 41,
  parameter int DIN1_WIDTH = 6,
  parameter int DOUT_WIDTH = 47
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic [DOUT_WIDTH-1:0] dout
);

  logic [DOUT_WIDTH-1:0] buff0_q;
  logic                  unused_reset;

  assign unused_reset = reset;

  // NOTE: the product register is pure datapath qualified by a valid bit
  // held elsewhere, so it carries no reset; its value is don't-care until
  // that valid bit is set.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for all clocked state, so every
    // register samples its inputs from before the edge.
    if (ce) buff0_q <= DOUT_WIDTH'(din0) * DOUT_WIDTH'(din1);
  end

  assign dout = buff0_q;

endmodule

// File: rtl/complex_mag_stream_rr_arb.sv
// Combinational round-robin arbiter.
//  req      : request vector
//  ptr      : highest-priority index for this cycle
//  en       : grant enable (gates grant and pointer advance, not index/any)
//  grant    : one-hot grant, zero when disabled or idle
//  index    : index of the winning requester (0 when idle)
//  any      : at least one request present
//  next_ptr : winner+1 mod NUM_REQ on an enabled grant, otherwise ptr
module complex_mag_stream_rr_arb
  import complex_mag_stream_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic                en,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] index,
  output logic                any,
  output logic [ID_WIDTH-1:0] next_ptr
);

  localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_REQ - 1);

  logic                found;
  logic [ID_WIDTH-1:0] sel;

  // Walk the ring starting at ptr; the explicit wrap at LAST keeps the
  // search correct when NUM_REQ is not a power of two.
  always_comb begin : search
    logic [ID_WIDTH-1:0] cand;
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned (which would infer a latch).
    found = 1'b0;
    sel   = '0;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
      cand = (cand == LAST) ? '0 : cand + ID_WIDTH'(1);
    end
  end

  assign any      = found;
  assign index    = sel;
  assign grant    = (en && found) ? (NUM_REQ'(1) << sel) : '0;
  assign next_ptr = (en && found) ? ((sel == LAST) ? '0 : sel + ID_WIDTH'(1)) : ptr;

endmodule

// File: rtl/complex_mag_stream_mul_arbiter.sv
// Shares one unsigned multiplier among NUM_REQ requesters, round-robin,
// one multiply per cycle, one-cycle latency, backpressure via the
// multiplier's clock enable.
//  clk     : clock, rising edge
//  reset_n : asynchronous reset, active-low
//  bus     : slave side of complex_mag_stream_mul_arbiter_if
//            (per-requester operand channels, shared tagged result channel)
module complex_mag_stream_mul_arbiter
  import complex_mag_stream_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = MUL_A_W,
  parameter int B_WIDTH  = MUL_B_W,
  parameter int P_WIDTH  = MUL_P_W,
  parameter int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  complex_mag_stream_mul_arbiter_if.slave  bus
);

  logic                adv;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                grant_any;
  logic [ID_WIDTH-1:0] next_ptr;

  logic [A_WIDTH-1:0]  din0;
  logic [B_WIDTH-1:0]  din1;
  logic [P_WIDTH-1:0]  dout;

  logic                tag_v_q,  tag_v_d;
  logic [ID_WIDTH-1:0] tag_id_q, tag_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  // The pipeline moves whenever the output slot is empty or being drained.
  // Qualifying with reset_n keeps every req_ready low while reset is held.
  assign adv = reset_n & (~tag_v_q | bus.res_ready);

  complex_mag_stream_rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req      (bus.req_valid),
    .ptr      (rr_ptr_q),
    .en       (adv),
    .grant    (grant),
    .index    (grant_idx),
    .any      (grant_any),
    .next_ptr (next_ptr)
  );

  assign bus.req_ready = grant;

  // grant is one-hot or zero, so OR-ing the selected slices is a plain mux
  // that yields zero operands when nothing is granted.
  always_comb begin
    din0 = '0;
    din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        din0 = bus.req_a[i*A_WIDTH +: A_WIDTH];
        din1 = bus.req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  complex_mag_stream_mul_41ns_6ns_47_2_1 #(
    .DIN0_WIDTH (A_WIDTH),
    .DIN1_WIDTH (B_WIDTH),
    .DOUT_WIDTH (P_WIDTH)
  ) u_mul (
    .clk   (clk),
    .reset (1'b0),
    .ce    (adv),
    .din0  (din0),
    .din1  (din1),
    .dout  (dout)
  );

  // Tag travels alongside the product; both load on adv only, so a stall
  // freezes valid, id and product together.
  always_comb begin
    tag_v_d  = adv ? grant_any : tag_v_q;
    tag_id_d = adv ? grant_idx : tag_id_q;
    rr_ptr_d = next_ptr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v_q  <= 1'b0;
      tag_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.res_valid = tag_v_q;
  assign bus.res_id    = tag_id_q;
  assign bus.res_p     = dout;

endmodule

// File: tb/tb_complex_mag_stream_mul_arbiter.sv
// Self-checking bench for complex_mag_stream_mul_arbiter: directed steps
// followed by a random soak, with a scoreboard fed on every operand transfer
// and drained on every accepted result.
module tb_complex_mag_stream_mul_arbiter;
  import complex_mag_stream_pkg::*;

  localparam int N  = 4;
  localparam int AW = MUL_A_W;
  localparam int BW = MUL_B_W;
  localparam int PW = MUL_P_W;
  localparam int IW = clog2(N);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [63:0]   p;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  complex_mag_stream_mul_arbiter_if #(
    .NUM_REQ (N), .A_WIDTH (AW), .B_WIDTH (BW), .P_WIDTH (PW), .ID_WIDTH (IW)
  ) bus ();

  complex_mag_stream_mul_arbiter #(
    .NUM_REQ (N), .A_WIDTH (AW), .B_WIDTH (BW), .P_WIDTH (PW), .ID_WIDTH (IW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int     checks = 0;
  int     errors = 0;
  exp_t   sb_q[$];
  int     waits[N];
  exp_t   mon_e;
  logic [N-1:0] mon_xfer;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    bus.req_a[i*AW +: AW] = a;
    bus.req_b[i*BW +: BW] = b;
  endtask

  function automatic logic [AW-1:0] rand_a();
    return AW'({$urandom, $urandom});
  endfunction

  // Monitor: sampled on the falling edge, when inputs and DUT outputs are
  // stable for the coming rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      check("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
      check("ready_without_valid", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
      if (bus.res_valid && bus.res_ready) begin
        check("sb_result_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("sb_res_id", 64'(bus.res_id), 64'(mon_e.id));
          check("sb_res_p", 64'(bus.res_p), mon_e.p);
        end
      end
      mon_xfer = bus.req_valid & bus.req_ready;
      for (int i = 0; i < N; i++) begin
        if (mon_xfer[i]) begin
          mon_e.id = IW'(i);
          mon_e.p  = 64'(bus.req_a[i*AW +: AW]) * 64'(bus.req_b[i*BW +: BW]);
          sb_q.push_back(mon_e);
        end
      end
      // Starvation: a requester holding valid sees at most N-1 foreign transfers.
      if (|mon_xfer) begin
        for (int i = 0; i < N; i++) begin
          if (mon_xfer[i] || !bus.req_valid[i]) waits[i] = 0;
          else begin
            waits[i]++;
            check("starvation_bound", 64'(waits[i] <= N - 1), 64'd1);
          end
        end
      end
    end
  end

  logic [N-1:0] last_xfer;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    last_xfer     = '0;

    // Reset state, with every requester asking.
    bus.req_valid = '1;
    @(negedge clk);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_id", 64'(bus.res_id), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    step();
    bus.req_valid = '0;
    reset_n = 1'b1;
    step();

    // Single request from requester 2.
    set_req(2, 41'd5, 6'd7);
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("t1_req_ready", 64'(bus.req_ready), 64'b0100);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_res_valid", 64'(bus.res_valid), 64'd1);
    check("t1_res_id", 64'(bus.res_id), 64'd2);
    check("t1_res_p", 64'(bus.res_p), 64'd35);
    check("t1_rr_ptr", 64'(dut.rr_ptr_q), 64'd3);
    step();
    @(negedge clk);
    check("t1_idle", 64'(bus.res_valid), 64'd0);
    step();

    // All requesters valid, full rate: grants rotate from pointer 3 with no bubble.
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_req(i, rand_a(), BW'($urandom));
      @(negedge clk);
      check("t2_grant", 64'(bus.req_ready), 64'(N'(1) << ((3 + k) % N)));
      if (k > 0) begin
        check("t2_no_bubble", 64'(bus.res_valid), 64'd1);
        check("t2_res_id", 64'(bus.res_id), 64'((3 + k - 1) % N));
      end
      step();
    end

    // Backpressure for 3 cycles with the last product (from requester 2) pending.
    bus.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_res_valid", 64'(bus.res_valid), 64'd1);
      check("t3_res_id", 64'(bus.res_id), 64'd2);
      check("t3_req_ready", 64'(bus.req_ready), 64'd0);
      check("t3_rr_ptr", 64'(dut.rr_ptr_q), 64'd3);
      check("t3_sb_depth", 64'(sb_q.size()), 64'd1);
      if (sb_q.size() != 0) check("t3_res_p_held", 64'(bus.res_p), sb_q[0].p);
      step();
    end
    // Accept and issue in the same cycle, then back-to-back result.
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("t3_reissue_ready", 64'(bus.req_ready), 64'b1000);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t3_b2b_valid", 64'(bus.res_valid), 64'd1);
    check("t3_b2b_id", 64'(bus.res_id), 64'd3);
    step();
    @(negedge clk);
    check("t3_drained_valid", 64'(bus.res_valid), 64'd0);
    check("t3_no_loss_no_dup", 64'(sb_q.size()), 64'd0);
    step();

    // Maximum operands: (2^41-1)*63 uses the full 47-bit product.
    set_req(1, '1, '1);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("t4_req_ready", 64'(bus.req_ready), 64'b0010);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t4_res_id", 64'(bus.res_id), 64'd1);
    check("t4_res_p", 64'(bus.res_p), 64'h7DFF_FFFF_FFC1);
    check("t4_rr_ptr", 64'(dut.rr_ptr_q), 64'd2);
    step();

    // Reset while a result is stalled.
    set_req(0, 41'd9, 6'd3);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b0;
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t5_pending", 64'(bus.res_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    bus.req_valid = '1;
    #1;
    check("t5_async_res_valid", 64'(bus.res_valid), 64'd0);
    check("t5_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    check("t5_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    step();
    reset_n = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5_no_stale", 64'(bus.res_valid), 64'd0);
      step();
    end
    set_req(2, 41'd100, 6'd50);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("t5_new_ready", 64'(bus.req_ready), 64'b0100);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t5_new_res_id", 64'(bus.res_id), 64'd2);
    check("t5_new_res_p", 64'(bus.res_p), 64'd5000);
    step();

    // Random soak: requesters hold valid until served (with rare early drops).
    last_xfer = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || last_xfer[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i, rand_a(), BW'($urandom));
        end else if ($urandom_range(0, 63) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      last_xfer = bus.req_valid & bus.req_ready;
      step();
    end

    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("soak_drained_valid", 64'(bus.res_valid), 64'd0);
    check("soak_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
